// File: rtl/uart_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM states,
// default frame sizing and the XOR checksum step.
package uart_sched_pkg;

  localparam int MAXLEN_DEF = 16;
  localparam int LENW_DEF   = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic [7:0] chk_step(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr.
// Ports: req, ptr in; one-hot gnt and its index idx out.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler in front of a byte UART.
// Ports: clk, rst (sync, active-high); req/req_len/req_data
// from NREQ sources; ack/gnt_id/busy status; tx_data/
// tx_valid/tx_ready byte handshake. Optional trailing XOR
// checksum byte when UART_TX_CHKSUM_EN is defined.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MAXLEN  = MAXLEN_DEF,
  parameter int LENW    = LENW_DEF,
  parameter int GAP_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LENW-1:0]     req_len,
  input  logic [NREQ*MAXLEN*8-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int IW = $clog2(NREQ);
  localparam int GW =
    (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t st, st_nxt;

  logic [IW-1:0]       ptr;
  logic [IW-1:0]       pick_id;
  logic [NREQ-1:0]     pick_oh;
  logic [LENW-1:0]     raw_len;
  logic [LENW-1:0]     lat_len;
  logic [MAXLEN*8-1:0] fbuf;
  logic [LENW-1:0]     flen;
  logic [LENW-1:0]     idx;
  logic [GW-1:0]       gap_cnt;
  logic                xfer;
  logic                last;
`ifdef UART_TX_CHKSUM_EN
  logic [7:0]          chk;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_id)
  );

  assign raw_len = req_len[int'(pick_id)*LENW +: LENW];
  assign lat_len = (raw_len > LENW'(MAXLEN)) ?
                   LENW'(MAXLEN) : raw_len;
  assign xfer    = tx_valid && tx_ready;
  assign last    = (idx == flen - LENW'(1));

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IW'(NREQ - 1);
      gnt_id  <= '0;
      fbuf    <= '0;
      flen    <= '0;
      idx     <= '0;
      gap_cnt <= '0;
`ifdef UART_TX_CHKSUM_EN
      chk     <= '0;
`endif
    end else begin
      case (st)
        ST_IDLE: begin
          if (|pick_oh) begin
            gnt_id <= pick_id;
            ptr    <= pick_id;
            fbuf   <= req_data[int'(pick_id)*MAXLEN*8
                               +: MAXLEN*8];
            flen   <= lat_len;
            idx    <= '0;
`ifdef UART_TX_CHKSUM_EN
            chk    <= '0;
`endif
          end
        end
        ST_SEND: begin
          if (xfer) begin
            idx <= idx + LENW'(1);
`ifdef UART_TX_CHKSUM_EN
            chk <= chk_step(chk, tx_data);
`endif
          end
        end
        ST_DONE: gap_cnt <= '0;
        ST_GAP:  gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  // GAP lasts GAP_CYC+1 cycles so IDLE is reached
  // GAP_CYC+2 cycles after the ack cycle.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: begin
        if (|pick_oh)
          st_nxt = (lat_len == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (xfer && last)
`ifdef UART_TX_CHKSUM_EN
          st_nxt = ST_CHK;
`else
          st_nxt = ST_DONE;
`endif
      end
      ST_CHK: begin
`ifdef UART_TX_CHKSUM_EN
        if (xfer) st_nxt = ST_DONE;
`else
        st_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        st_nxt = (GAP_CYC == 0 || flen == '0) ?
                 ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_CYC)) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack      = '0;
    busy     = (st != ST_IDLE);
    tx_valid = 1'b0;
    tx_data  = '0;
    case (st)
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = fbuf[8*int'(idx) +: 8];
      end
`ifdef UART_TX_CHKSUM_EN
      ST_CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk;
      end
`endif
      ST_DONE: ack[gnt_id] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=3, GAP_CYC=4)
// with a queue-based frame and round-robin reference model.
module tb_uart_tx_sched;

  localparam int NREQ = 3;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int GAP  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*LW-1:0]     req_len;
  logic [NREQ*MAXL*8-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [1:0]             gnt_id;
  logic                   busy;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  uart_tx_sched #(
    .NREQ    (NREQ),
    .MAXLEN  (MAXL),
    .LENW    (LW),
    .GAP_CYC (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_len  (req_len),
    .req_data (req_data),
    .ack      (ack),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_ptr = NREQ - 1;

  logic [7:0] mem [NREQ][MAXL];
  int         mlen [NREQ];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         order[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int s);
    req_len[s*LW +: LW] = LW'(mlen[s]);
    for (int k = 0; k < MAXL; k++)
      req_data[(s*MAXL+k)*8 +: 8] = mem[s][k];
  endtask

  task automatic post(input int s, input int l);
    mlen[s] = l;
    for (int k = 0; k < MAXL; k++)
      mem[s][k] = 8'($urandom);
    drive_src(s);
  endtask

  // Expected wire image of source s's frame.
  task automatic build_exp(input int s);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = (mlen[s] > MAXL) ? MAXL : mlen[s];
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mem[s][k]);
      x = x ^ mem[s][k];
    end
`ifdef UART_TX_CHKSUM_EN
    if (n > 0) exp_q.push_back(x);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy stuck high");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_len = '0;
    req_data = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    total++;
    if (ack !== 3'b000) begin
      bad++;
      $display("FAIL rst_ack: got %b want 000", ack);
    end
    total++;
    if (gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL rst_gnt: got %0d want 0", gnt_id);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b want 0", tx_valid);
    end
    total++;
    if (tx_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_data: got %h want 00", tx_data);
    end
    rst = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    logic [7:0] b [3];
    int n;
    b[0] = 8'h41;
    b[1] = 8'h42;
    b[2] = 8'h43;
    mlen[1] = 3;
    for (int k = 0; k < MAXL; k++)
      mem[1][k] = (k < 3) ? b[k] : 8'hee;
    drive_src(1);
    req = 3'b010;
    tick();
    req = '0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== b[k]) begin
        bad++;
        $display("FAIL single_byte%0d: got v=%b %h want 1 %h",
                 k, tx_valid, tx_data, b[k]);
      end
      tick();
    end
`ifdef UART_TX_CHKSUM_EN
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h40) begin
      bad++;
      $display("FAIL single_chk: got %h want 40", tx_data);
    end
    tick();
`endif
    total++;
    if (ack !== 3'b010) begin
      bad++;
      $display("FAIL single_ack: got %b want 010", ack);
    end
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n != GAP + 2) begin
      bad++;
      $display("FAIL single_gap: busy fell after %0d want %0d",
               n, GAP + 2);
    end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    int got[$];
    int n, id;
    bit rearmed;
    logic [NREQ-1:0] seen;
    do_reset();
    for (int s = 0; s < NREQ; s++) post(s, 1);
    req = 3'b111;
    rearmed = 1'b0;
    n = 0;
    while (got.size() < 4 && n < 300) begin
      seen = ack;
      if (seen != '0) begin
        id = 0;
        for (int i = 0; i < NREQ; i++)
          if (seen[i]) id = i;
        got.push_back(id);
        if (id == 0 && !rearmed) begin
          rearmed = 1'b1;
          post(0, 1);
        end else begin
          req[id] = 1'b0;
        end
      end
      tick();
      n++;
    end
    req = '0;
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL rr_count: got %0d acks want 4",
               got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] != ((i == 3) ? 0 : i)) begin
          bad++;
          $display("FAIL rr_order%0d: got %0d want %0d",
                   i, got[i], (i == 3) ? 0 : i);
        end
      end
    end
    wait_idle();
    model_ptr = 0;
  endtask

  task automatic test_backpressure();
    wait_idle();
    post(2, 4);
    req = 3'b100;
    tick();
    req = '0;
    total++;
    if (tx_data !== mem[2][0]) begin
      bad++;
      $display("FAIL bp_b0: got %h want %h",
               tx_data, mem[2][0]);
    end
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== mem[2][1]) begin
        bad++;
        $display("FAIL bp_hold%0d: got %h want %h",
                 i, tx_data, mem[2][1]);
      end
      tick();
    end
    tx_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== mem[2][k]) begin
        bad++;
        $display("FAIL bp_b%0d: got %h want %h",
                 k, tx_data, mem[2][k]);
      end
      tick();
    end
`ifdef UART_TX_CHKSUM_EN
    tick();
`endif
    total++;
    if (ack !== 3'b100) begin
      bad++;
      $display("FAIL bp_ack: got %b want 100", ack);
    end
    model_ptr = 2;
    wait_idle();
  endtask

  task automatic test_zero_len();
    wait_idle();
    post(0, 0);
    req = 3'b001;
    tick();
    req = '0;
    total++;
    if (ack !== 3'b001 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_ack: got ack=%b v=%b want 001 0",
               ack, tx_valid);
    end
    tick();
    total++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_nogap: got busy=%b v=%b want 0 0",
               busy, tx_valid);
    end
    model_ptr = 0;
  endtask

  task automatic test_len_clip();
    int n;
    bit ok;
    wait_idle();
    post(1, 31);
    req = 3'b010;
    got_q.delete();
    n = 0;
    tick();
    req = '0;
    while (ack == '0 && n < 100) begin
      if (tx_valid) got_q.push_back(tx_data);
      tick();
      n++;
    end
    build_exp(1);
    ok = (got_q.size() == exp_q.size());
    if (ok)
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) ok = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clip_frame: got %0d bytes want %0d",
               got_q.size(), exp_q.size());
    end
    model_ptr = 1;
    wait_idle();
  endtask

  task automatic test_checksum();
    int n;
    int want_n;
    logic [7:0] want_last;
    wait_idle();
    mlen[0] = 3;
    for (int k = 0; k < MAXL; k++) mem[0][k] = 8'h00;
    mem[0][0] = 8'h12;
    mem[0][1] = 8'h34;
    mem[0][2] = 8'h56;
    drive_src(0);
    req = 3'b001;
    got_q.delete();
    n = 0;
    tick();
    req = '0;
    while (ack == '0 && n < 100) begin
      if (tx_valid) got_q.push_back(tx_data);
      tick();
      n++;
    end
`ifdef UART_TX_CHKSUM_EN
    want_n = 4;
    want_last = 8'h70;
`else
    want_n = 3;
    want_last = 8'h56;
`endif
    total++;
    if (got_q.size() != want_n) begin
      bad++;
      $display("FAIL chk_len: got %0d want %0d",
               got_q.size(), want_n);
    end else begin
      total++;
      if (got_q[want_n-1] !== want_last) begin
        bad++;
        $display("FAIL chk_last: got %h want %h",
                 got_q[want_n-1], want_last);
      end
    end
    total++;
    if (ack !== 3'b001) begin
      bad++;
      $display("FAIL chk_ack: got %b want 001", ack);
    end
    model_ptr = 0;
    wait_idle();
  endtask

  task automatic test_random();
    int sub, k, cyc, cur;
    bit ok, tr, stall;
    logic [7:0] pdata;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      sub = $urandom_range(1, 7);
      order.delete();
      for (int s = 0; s < NREQ; s++)
        if (sub[s])
          post(s, ($urandom_range(0, 7) == 0) ?
                  31 : $urandom_range(0, 18));
      for (int i = 1; i <= NREQ; i++)
        if (sub[(model_ptr + i) % NREQ])
          order.push_back((model_ptr + i) % NREQ);
      req = NREQ'(sub);
      got_q.delete();
      k = 0;
      cyc = 0;
      stall = 0;
      pdata = '0;
      while (k < order.size() && cyc < 2000) begin
        cur = order[k];
        if (stall) begin
          total++;
          if (tx_valid !== 1'b1 || tx_data !== pdata) begin
            bad++;
            $display("FAIL rnd_hold: got %h want %h",
                     tx_data, pdata);
          end
        end
        if (tx_valid) begin
          total++;
          if (gnt_id !== 2'(cur)) begin
            bad++;
            $display("FAIL rnd_gnt: got %0d want %0d",
                     gnt_id, cur);
          end
          // Inputs may change freely once latched.
          req_data[cur*MAXL*8 +: MAXL*8] =
            {MAXL/4{$urandom}};
        end
        if (ack != '0) begin
          total++;
          if (ack !== NREQ'(1 << cur)) begin
            bad++;
            $display("FAIL rnd_ack: got %b want %0d",
                     ack, cur);
          end
          build_exp(cur);
          ok = (got_q.size() == exp_q.size());
          if (ok)
            foreach (exp_q[i])
              if (got_q[i] !== exp_q[i]) ok = 0;
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL rnd_frame src%0d: %0d bytes want %0d",
                     cur, got_q.size(), exp_q.size());
          end
          req[cur] = 1'b0;
          got_q.delete();
          model_ptr = cur;
          k++;
        end
        tr = ($urandom_range(0, 3) != 0);
        tx_ready = tr;
        if (tx_valid && tr) got_q.push_back(tx_data);
        stall = tx_valid && !tr;
        pdata = tx_data;
        tick();
        cyc++;
      end
      if (k < order.size()) begin
        total++;
        bad++;
        $display("FAIL rnd_timeout: %0d of %0d frames",
                 k, order.size());
      end
      req = '0;
      tx_ready = 1'b1;
      wait_idle();
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    post(2, 5);
    req = 3'b100;
    tick();
    tick();
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 ||
        ack !== 3'b000 || gnt_id !== 2'd0 ||
        tx_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst: v=%b b=%b a=%b g=%0d d=%h",
               tx_valid, busy, ack, gnt_id, tx_data);
    end
    rst = 1'b0;
    tick();
    total++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_noack: ack=%b busy=%b want 000 0",
               ack, busy);
    end
    post(0, 2);
    post(2, 2);
    req = 3'b101;
    tick();
    total++;
    if (gnt_id !== 2'd0 || tx_valid !== 1'b1 ||
        tx_data !== mem[0][0]) begin
      bad++;
      $display("FAIL mid_restart: g=%0d d=%h want 0 %h",
               gnt_id, tx_data, mem[0][0]);
    end
    req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_len_clip();
    test_checksum();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
